// File: rtl/mem_stage.sv
// Memory stage: issues lw/sw to a variable-latency data memory over req/ack,
// stalls upstream while the access is outstanding and owns the M/W latch.
module mem_stage #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       xm_insn,
    input  logic [31:0]       xm_o,
    input  logic [31:0]       xm_b,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_wren,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       mw_insn,
    output logic [31:0]       mw_o,
    output logic [31:0]       mw_d,
    output logic              mem_err,
    output logic [31:0]       stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [4:0] OP_SW = 5'b00111;
    localparam logic [4:0] OP_LW = 5'b01000;

    state_t r_state;
    state_t w_next;

    logic [4:0]        w_op;
    logic              w_is_sw;
    logic              w_is_lw;
    logic              w_is_mem;
    logic              w_timeout;
    logic              w_stall;

    logic              r_req;
    logic              r_wren;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mw_insn;
    logic [31:0]       r_mw_o;
    logic [31:0]       r_mw_d;
    logic              r_err;
    logic [31:0]       r_stall_cnt;
    logic [31:0]       r_rdata;
    logic [31:0]       r_wcnt;

    assign w_op     = xm_insn[31:27];
    assign w_is_sw  = (w_op == OP_SW);
    assign w_is_lw  = (w_op == OP_LW);
    assign w_is_mem = w_is_sw | w_is_lw;

    // Fires on the last permitted WAIT cycle; an ack in that cycle still wins.
    assign w_timeout = (TIMEOUT != 0) && (r_state == S_WAIT) &&
                       !dmem_ack && (r_wcnt == TIMEOUT - 1);

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_is_mem) begin
                    w_stall = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (dmem_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_req       <= 1'b0;
            r_wren      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mw_insn   <= '0;
            r_mw_o      <= '0;
            r_mw_d      <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
            r_rdata     <= '0;
            r_wcnt      <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_is_mem) begin
                        r_req     <= 1'b1;
                        r_wren    <= w_is_sw;
                        r_addr    <= xm_o[ADDR_W-1:0];
                        r_wdata   <= xm_b;
                        r_mw_insn <= '0;
                        r_mw_o    <= '0;
                        r_mw_d    <= '0;
                        r_wcnt    <= '0;
                    end else begin
                        r_mw_insn <= xm_insn;
                        r_mw_o    <= xm_o;
                        r_mw_d    <= '0;
                    end
                end
                S_WAIT: begin
                    r_mw_insn <= '0;
                    r_mw_o    <= '0;
                    r_mw_d    <= '0;
                    if (dmem_ack) begin
                        r_rdata <= r_wren ? 32'd0 : dmem_rdata;
                        r_req   <= 1'b0;
                        r_wren  <= 1'b0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_req   <= 1'b0;
                        r_wren  <= 1'b0;
                    end else begin
                        r_wcnt <= r_wcnt + 32'd1;
                    end
                end
                S_DONE: begin
                    r_mw_insn <= xm_insn;
                    r_mw_o    <= xm_o;
                    r_mw_d    <= r_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    assign stall      = w_stall;
    assign dmem_req   = r_req;
    assign dmem_wren  = r_wren;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign mw_insn    = r_mw_insn;
    assign mw_o       = r_mw_o;
    assign mw_d       = r_mw_d;
    assign mem_err    = r_err;
    assign stall_cnt  = r_stall_cnt;

endmodule
